// File: rtl/output_deskewer.sv
// Purpose: re-aligns the skewed column outputs of a systolic array into whole rows, tagging each row with an index and an end-of-frame flag.
// Latency: lane i is delayed by MATRIX_SIZE-1-i enabled cycles, so lane 0 to valid_out is MATRIX_SIZE-1 enabled cycles; the last lane is combinational.
// Backpressure: enable_in low freezes every delay line, the valid pipeline and the row counter; valid_out is forced low while frozen.
module output_deskewer #(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_SIZE   = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable_in,
    input  logic                                   valid_in,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  data_in,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  data_aligned,
    output logic                                   valid_out,
    output logic [$clog2(MATRIX_SIZE):0]           row_idx,
    output logic                                   frame_done
);

    localparam int              RW       = $clog2(MATRIX_SIZE) + 1;
    localparam logic [RW-1:0]   LAST_ROW = RW'(MATRIX_SIZE - 1);

    logic          valid_tail;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_d;

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        localparam int DEPTH = MATRIX_SIZE - 1 - i;

        if (DEPTH == 0) begin : g_pass
            // The most-lagging lane is already aligned with the wavefront.
            assign data_aligned[i] = data_in[i];
        end else begin : g_dly
            logic [DATA_SIZE-1:0] dly_q [DEPTH];
            logic [DATA_SIZE-1:0] dly_d [DEPTH];

            // Shift the lane's delay line one slot per enabled cycle.
            always_comb begin
                dly_d = dly_q;
                if (enable_in) begin
                    dly_d[0] = data_in[i];
                    for (int k = 1; k < DEPTH; k++) begin
                        dly_d[k] = dly_q[k-1];
                    end
                end
            end

            // Delay line storage; reset wins over enable.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dly_q <= '{default: '0};
                end else begin
                    dly_q <= dly_d;
                end
            end

            // Registers are presented as-is even when the row is not valid.
            assign data_aligned[i] = dly_q[DEPTH-1];
        end
    end

    if (MATRIX_SIZE > 1) begin : g_vpipe
        logic [MATRIX_SIZE-2:0] vpipe_q;
        logic [MATRIX_SIZE-2:0] vpipe_d;

        // Carry the lane-0 valid alongside lane 0's data, same depth.
        always_comb begin
            vpipe_d = vpipe_q;
            if (enable_in) begin
                vpipe_d[0] = valid_in;
                for (int k = 1; k < MATRIX_SIZE - 1; k++) begin
                    vpipe_d[k] = vpipe_q[k-1];
                end
            end
        end

        // Valid pipeline storage; reset drops all in-flight rows.
        always_ff @(posedge clk) begin
            if (reset) begin
                vpipe_q <= '0;
            end else begin
                vpipe_q <= vpipe_d;
            end
        end

        assign valid_tail = vpipe_q[MATRIX_SIZE-2];
    end else begin : g_vpass
        assign valid_tail = valid_in;
    end

    assign valid_out  = valid_tail & enable_in;
    assign frame_done = valid_out & (row_q == LAST_ROW);
    assign row_idx    = row_q;

    // Advance the row index on every emitted row, wrapping at the frame end.
    always_comb begin
        row_d = row_q;
        if (valid_out) begin
            row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        end
    end

    // Row counter storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

endmodule

// File: tb/tb_output_deskewer.sv
// Purpose: self-checking bench for output_deskewer (4 lanes x 32 bits): table vectors, corner-case sequences, random traffic vs a history model.
// Latency: expected outputs are derived from the history of enabled input samples, lane i looking back 3-i samples.
// Backpressure: enable_in is toggled directly; stalls must freeze everything and suppress valid_out.
module tb_output_deskewer;
    localparam int M = 4;
    localparam int W = 32;

    typedef logic [M-1:0][W-1:0] row_t;

    logic       clk = 1'b0;
    logic       reset, enable_in, valid_in;
    row_t       data_in, data_aligned;
    logic       valid_out, frame_done;
    logic [2:0] row_idx;

    output_deskewer #(.MATRIX_SIZE(M), .DATA_SIZE(W)) dut (
        .clk(clk), .reset(reset), .enable_in(enable_in), .valid_in(valid_in),
        .data_in(data_in), .data_aligned(data_aligned), .valid_out(valid_out),
        .row_idx(row_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: every enabled sample since the last reset, plus rows emitted.
    row_t dhist[$];
    bit   vhist[$];
    int   rows_seen = 0;

    // Outputs seen on the most recent step.
    bit   o_vld, o_fd;
    logic [2:0] o_row;
    row_t o_d;

    // Per-enabled-cycle records of the last frame run.
    bit         ov[32];
    bit         ofd[32];
    logic [2:0] orow[32];
    row_t       od[32];

    typedef struct {
        bit         en;
        bit         vld;
        row_t       d;
        bit         ev;
        logic [2:0] er;
        bit         efd;
        row_t       ed;
    } vec_t;
    vec_t tbl[8];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < M; i++) r[i] = $urandom;
        return r;
    endfunction

    // Drive one cycle, compare every output against the model, then advance the model.
    task automatic step(bit rst, bit en, bit vld, row_t d, string tag);
        int   e;
        int   dep;
        bit   ev;
        logic [2:0] er;
        row_t ed;
        @(negedge clk);
        reset = rst; enable_in = en; valid_in = vld; data_in = d;
        #2;
        e = vhist.size();
        for (int i = 0; i < M; i++) begin
            dep = M - 1 - i;
            if (dep == 0)     ed[i] = d[i];
            else if (e >= dep) ed[i] = dhist[e-dep][i];
            else              ed[i] = '0;
        end
        ev = 1'b0;
        if (en && e >= M - 1) ev = vhist[e-(M-1)];
        er = 3'(rows_seen % M);
        for (int i = 0; i < M; i++) check($sformatf("%s.lane%0d", tag, i), data_aligned[i], ed[i]);
        check({tag, ".valid_out"},  32'(valid_out),  32'(ev));
        check({tag, ".row_idx"},    32'(row_idx),    32'(er));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(ev && er == 3'(M - 1)));
        o_vld = valid_out; o_fd = frame_done; o_row = row_idx; o_d = data_aligned;
        if (rst) begin
            dhist.delete(); vhist.delete(); rows_seen = 0;
        end else begin
            if (ev) rows_seen++;
            if (en) begin dhist.push_back(d); vhist.push_back(vld); end
        end
    endtask

    // Reset, then feed nrows skewed rows (lane i of row r = base+0x100*r+i at enabled cycle r+i).
    task automatic run_frame(int nrows, int mask, int stall_after, int stall_len,
                             logic [31:0] base, logic [2:0] stall_row, string tag);
        row_t d;
        int   r;
        step(1'b1, 1'b1, 1'b1, rand_row(), {tag, ".rst"});
        for (int c = 0; c < nrows + M; c++) begin
            for (int i = 0; i < M; i++) begin
                r = c - i;
                d[i] = (r >= 0 && r < nrows) ? base + 32'(32'h100 * r + i) : '0;
            end
            step(1'b0, 1'b1, (c < nrows) && mask[c], d, tag);
            ov[c] = o_vld; ofd[c] = o_fd; orow[c] = o_row; od[c] = o_d;
            if (c == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    step(1'b0, 1'b0, 1'($urandom), rand_row(), {tag, ".hold"});
                    check({tag, ".stall_valid"}, 32'(o_vld), 32'd0);
                    check({tag, ".stall_row"},   32'(o_row), 32'(stall_row));
                end
            end
        end
    endtask

    initial begin
        int fd_cnt;
        row_t z;
        z = '0;
        reset = 1'b1; enable_in = 1'b0; valid_in = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);

        // Reset state: lanes 0..2 zero, lane 3 follows input.
        step(1'b0, 1'b0, 1'b0, {32'hCAFE0003, 32'h3, 32'h2, 32'h1}, "reset_state");
        check("reset.lane3", o_d[3], 32'hCAFE0003);
        check("reset.lane0", o_d[0], 32'h0);

        // Full frame from a table of skewed inputs and expected rows.
        for (int c = 0; c < 8; c++) begin
            tbl[c].en  = 1'b1;
            tbl[c].vld = (c < 4);
            for (int i = 0; i < M; i++) begin
                tbl[c].d[i]  = (c - i >= 0 && c - i < 4) ? 32'(32'h100 * (c - i) + i) : 32'h0;
                tbl[c].ed[i] = 32'(32'h100 * (c - 3) + i);
            end
            tbl[c].ev  = (c >= 3 && c <= 6);
            tbl[c].er  = tbl[c].ev ? 3'(c - 3) : 3'd0;
            tbl[c].efd = (c == 6);
        end
        step(1'b1, 1'b0, 1'b0, z, "tbl.rst");
        for (int c = 0; c < 8; c++) begin
            step(1'b0, tbl[c].en, tbl[c].vld, tbl[c].d, "tbl");
            check($sformatf("tbl%0d.valid", c), 32'(o_vld), 32'(tbl[c].ev));
            check($sformatf("tbl%0d.row", c),   32'(o_row), 32'(tbl[c].er));
            check($sformatf("tbl%0d.done", c),  32'(o_fd),  32'(tbl[c].efd));
            if (tbl[c].ev) begin
                for (int i = 0; i < M; i++)
                    check($sformatf("tbl%0d.data%0d", c, i), o_d[i], tbl[c].ed[i]);
            end
        end

        // Single row: valid exactly at cycle 3.
        run_frame(1, 1, -1, 0, 32'h10, 3'd0, "single");
        for (int c = 0; c < 5; c++) check($sformatf("single.valid%0d", c), 32'(ov[c]), 32'(c == 3));
        for (int i = 0; i < M; i++) check($sformatf("single.data%0d", i), od[3][i], 32'h10 + 32'(i));
        check("single.row", 32'(orow[3]), 32'd0);
        check("single.done", 32'(ofd[3]), 32'd0);

        // Stall of two cycles after enabled cycle 4; rows 2,3 emerge afterwards.
        run_frame(4, 'hF, 4, 2, 32'h0, 3'd2, "stall");
        for (int c = 3; c < 7; c++) check($sformatf("stall.valid%0d", c), 32'(ov[c]), 32'd1);
        for (int i = 0; i < M; i++) begin
            check($sformatf("stall.row2_%0d", i), od[5][i], 32'h200 + 32'(i));
            check($sformatf("stall.row3_%0d", i), od[6][i], 32'h300 + 32'(i));
        end
        check("stall.idx3", 32'(orow[6]), 32'd3);
        check("stall.done", 32'(ofd[6]), 32'd1);

        // Gapped valid 1,0,1.
        run_frame(3, 'b101, -1, 0, 32'h20, 3'd0, "gap");
        check("gap.v3", 32'(ov[3]), 32'd1);
        check("gap.v4", 32'(ov[4]), 32'd0);
        check("gap.v5", 32'(ov[5]), 32'd1);
        check("gap.r3", 32'(orow[3]), 32'd0);
        check("gap.r5", 32'(orow[5]), 32'd1);
        for (int i = 0; i < M; i++) check($sformatf("gap.d%0d", i), od[5][i], 32'h220 + 32'(i));

        // Wrap over five rows.
        run_frame(5, 'h1F, -1, 0, 32'h0, 3'd0, "wrap");
        fd_cnt = 0;
        for (int c = 0; c < 9; c++) fd_cnt += int'(ofd[c]);
        for (int r = 0; r < 5; r++) check($sformatf("wrap.row%0d", r), 32'(orow[3+r]), 32'(r % 4));
        check("wrap.done_count", 32'(fd_cnt), 32'd1);

        // Reset at cycle 2 of a frame discards everything in flight.
        step(1'b1, 1'b0, 1'b0, z, "mid.rst0");
        step(1'b0, 1'b1, 1'b1, {32'h0, 32'h0, 32'h0, 32'h40}, "mid");
        step(1'b0, 1'b1, 1'b1, {32'h0, 32'h0, 32'h41, 32'h140}, "mid");
        step(1'b1, 1'b1, 1'b1, {32'h0, 32'h42, 32'h141, 32'h240}, "mid.rst");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, z, "mid.after");
            check($sformatf("mid.valid%0d", k), 32'(o_vld), 32'd0);
            check($sformatf("mid.row%0d", k), 32'(o_row), 32'd0);
            for (int i = 0; i < M - 1; i++) check($sformatf("mid.d%0d_%0d", k, i), o_d[i], 32'h0);
        end

        // Random traffic with stalls and occasional resets against the model.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom), rand_row(), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
